// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous RAM between port C (CPU) and port D
//   (debug / program loader). Each port uses a req/ack handshake. One RAM
//   access is in flight at a time. C has priority. A starvation guard hands
//   the RAM to D after STARVE_LIMIT consecutive C grants made while D waited.
//
// Ports
//   clk, reset                 rising-edge clock, async active-low reset
//   c_req/c_we/c_addr/c_wdata  port C request (held until c_ack)
//   c_rdata, c_ack             port C read data (held) and 1-cycle completion
//   d_*                        same as port C, for port D
//   m_en/m_we/m_addr/m_wdata   RAM strobe/write/address/data (0 outside ISSUE)
//   m_rdata                    RAM read data, RD_LAT cycles after m_en
//   grant                      one-hot owner {D,C}, 00 when idle
//   busy                       transaction in progress
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no owner; arbitrate and latch winner's request
// ISSUE  | drive the RAM access for one cycle
// WAIT   | read only: RD_LAT cycles, capture m_rdata on the last
// RESP   | pulse winner's ack for one cycle
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 32,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [1:0]        grant,
  output logic              busy
);

  // wait counter holds RD_LAT-1 down to 0
  localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT);
  localparam int STV_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [1:0]         grant_q;
  logic               lat_we;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic [CNT_W-1:0]   wait_cnt;
  logic [STV_W-1:0]   starve;
  logic [DATA_W-1:0]  c_rdata_q, d_rdata_q;
  logic               any_req;
  logic               pick_d;

  assign any_req = c_req | d_req;

  // D wins when alone, or when both request and the guard has saturated
  always_comb begin
    pick_d = 1'b0;
    if (d_req && !c_req)
      pick_d = 1'b1;
    else if (d_req && c_req && (STARVE_LIMIT != 0) && (starve == STV_W'(STARVE_LIMIT)))
      pick_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = lat_we ? S_RESP : S_WAIT;
      S_WAIT:  if (wait_cnt == '0) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q   <= 2'b00;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      wait_cnt  <= '0;
      starve    <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (state == S_IDLE && any_req) begin
        grant_q   <= pick_d ? 2'b10 : 2'b01;
        lat_we    <= pick_d ? d_we    : c_we;
        lat_addr  <= pick_d ? d_addr  : c_addr;
        lat_wdata <= pick_d ? d_wdata : c_wdata;
        if (pick_d)
          starve <= '0;
        else if (d_req) begin
          if (starve != STV_W'(STARVE_LIMIT))
            starve <= starve + STV_W'(1);
        end else
          starve <= '0;
      end
      if (state == S_ISSUE && !lat_we)
        wait_cnt <= CNT_W'(RD_LAT - 1);
      else if (state == S_WAIT && wait_cnt != '0)
        wait_cnt <= wait_cnt - CNT_W'(1);
      if (state == S_WAIT && wait_cnt == '0) begin
        if (grant_q[0]) c_rdata_q <= m_rdata;
        else            d_rdata_q <= m_rdata;
      end
      if (state == S_RESP)
        grant_q <= 2'b00;
    end
  end

  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    c_ack   = 1'b0;
    d_ack   = 1'b0;
    if (state == S_ISSUE) begin
      m_en    = 1'b1;
      m_we    = lat_we;
      m_addr  = lat_addr;
      m_wdata = lat_wdata;
    end
    if (state == S_RESP) begin
      c_ack = grant_q[0];
      d_ack = grant_q[1];
    end
    busy    = (state != S_IDLE);
    grant   = grant_q;
    c_rdata = c_rdata_q;
    d_rdata = d_rdata_q;
  end

endmodule
